// File: rtl/unified_mem_ctrl.sv
// Unified single-ported memory shared by the instruction-fetch and data ports.
// A two-state FSM (IDLE/ACCESS) grants one port at a time. It runs a latency
// down-counter and returns a one-cycle ready strobe on the granted port.
//
//   state  | meaning
//   IDLE   | no access in flight; a pending request is granted at the next edge
//   ACCESS | granted access counting down; last cycle is the ready cycle
//
// Supported DEPTH_LOG2 range: 1..29.
module unified_mem_ctrl #(
  parameter int DATA_W       = 32,
  parameter int DEPTH_LOG2   = 6,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_req_i,
  input  logic [31:0]           i_addr_i,
  output logic [DATA_W-1:0]     i_rdata_o,
  output logic                  i_ready_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DATA_W/8-1:0]   d_be_i,
  input  logic [31:0]           d_addr_i,
  input  logic [DATA_W-1:0]     d_wdata_i,
  output logic [DATA_W-1:0]     d_rdata_o,
  output logic                  d_ready_o,
  output logic                  busy_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BE_W  = DATA_W / 8;
  localparam int SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]    LAT_LOAD   = 4'(LATENCY - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  localparam logic PORT_D = 1'b0;
  localparam logic PORT_I = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  port_q, port_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  i_ready_q, d_ready_q;
  logic [DATA_W-1:0]     i_rdata_q, d_rdata_q;

  logic                  rdy_d;
  logic                  commit;
  logic                  starve_full;
  logic                  grant_i;
  logic [DEPTH_LOG2-1:0] i_idx, d_idx;
  logic                  unused_addr_bits;

  // Word index only; byte offset and bits above the array depth wrap away.
  assign i_idx = i_addr_i[DEPTH_LOG2+1:2];
  assign d_idx = d_addr_i[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{i_addr_i[31:DEPTH_LOG2+2], i_addr_i[1:0],
                              d_addr_i[31:DEPTH_LOG2+2], d_addr_i[1:0]};

  // Data wins a tie unless the fetch port has waited through STARVE_LIMIT data grants.
  assign starve_full = (STARVE_LIMIT != 0) && (starve_q == STARVE_MAX);
  assign grant_i     = i_req_i && (!d_req_i || starve_full);

  // Next-state: grant and capture in IDLE, count down in ACCESS.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    starve_d = starve_q;
    commit   = 1'b0;
    if (state_q == IDLE) begin
      if (i_req_i || d_req_i) begin
        state_d = ACCESS;
        cnt_d   = LAT_LOAD;
        if (grant_i) begin
          port_d   = PORT_I;
          addr_d   = i_idx;
          we_d     = 1'b0;
          starve_d = '0;
        end else begin
          port_d  = PORT_D;
          addr_d  = d_idx;
          we_d    = d_we_i;
          be_d    = d_be_i;
          wdata_d = d_wdata_i;
          if (i_req_i && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
    end else begin
      if (cnt_q == '0) begin
        state_d = IDLE;
        commit  = we_q && (port_q == PORT_D);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
    rdy_d = (state_d == ACCESS) && (cnt_d == '0);
  end

  // Control state and registered outputs; read data is captured as the ready cycle begins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      port_q    <= PORT_D;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      starve_q  <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      port_q    <= port_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
      i_ready_q <= rdy_d && (port_d == PORT_I);
      d_ready_q <= rdy_d && (port_d == PORT_D);
      if (rdy_d && (port_d == PORT_I)) begin
        i_rdata_q <= mem_q[addr_d];
      end
      if (rdy_d && (port_d == PORT_D) && !we_d) begin
        d_rdata_q <= mem_q[addr_d];
      end
    end
  end

  // Byte-lane write commit at the edge closing the ready cycle; RAM is never reset.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      for (int k = 0; k < BE_W; k++) begin
        if (be_q[k]) begin
          mem_q[addr_q][k*8 +: 8] <= wdata_q[k*8 +: 8];
        end
      end
    end
  end

  assign i_ready_o = i_ready_q;
  assign d_ready_o = d_ready_q;
  assign i_rdata_o = i_rdata_q;
  assign d_rdata_o = d_rdata_q;
  assign busy_o    = (state_q == ACCESS);

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Scoreboard bench for unified_mem_ctrl (LATENCY=3, STARVE_LIMIT=2, 64 words).
module tb_unified_mem_ctrl;

  localparam int LAT = 3;
  localparam int SL  = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [64];
  exp_t        d_q[$];
  logic [31:0] i_q[$];
  bit          ord_q[$];   // 0 = data grant, 1 = fetch grant
  logic [31:0] last_d = '0;

  unified_mem_ctrl #(.DATA_W(32), .DEPTH_LOG2(6), .LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata), .i_ready_o(i_ready),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_rdata_o(d_rdata), .d_ready_o(d_ready), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [5:0] widx(input logic [31:0] a);
    return a[7:2];
  endfunction

  // Expected grant order when both ports start with nd / ni back-to-back requests.
  task automatic predict_order(input int nd, input int ni);
    int s = 0;
    while (nd > 0 || ni > 0) begin
      if (ni > 0 && (nd == 0 || (SL != 0 && s == SL))) begin
        ord_q.push_back(1'b1);
        s = 0;
        ni--;
      end else begin
        ord_q.push_back(1'b0);
        if (ni > 0 && s < SL) s++;
        nd--;
      end
    end
  endtask

  // Issue one data access at the current negedge; returns negedges waited and busy at the first one.
  task automatic d_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input bit keep,
                          output int n, output logic b1);
    exp_t e;
    e.we = we;
    e.data = '0;
    if (we) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) model_mem[widx(addr)][k*8 +: 8] = wdata[k*8 +: 8];
    end else begin
      e.data = model_mem[widx(addr)];
    end
    d_q.push_back(e);
    d_req = 1'b1; d_we = we; d_addr = addr; d_be = be; d_wdata = wdata;
    n = 0; b1 = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) b1 = busy;
      if (d_ready) break;
      if (n >= 60) begin
        chk(1'b0, "d_timeout", 32'(n), 32'(LAT));
        break;
      end
    end
    if (!keep) d_req = 1'b0;
  endtask

  task automatic i_fetch(input logic [31:0] addr, input bit keep, output int n, output logic b1);
    i_q.push_back(model_mem[widx(addr)]);
    i_req = 1'b1; i_addr = addr;
    n = 0; b1 = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      if (n == 1) b1 = busy;
      if (i_ready) break;
      if (n >= 60) begin
        chk(1'b0, "i_timeout", 32'(n), 32'(LAT));
        break;
      end
    end
    if (!keep) i_req = 1'b0;
  endtask

  // Single data access from idle with latency and busy checks.
  task automatic d_chk(input string name, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    int n; logic b1;
    @(negedge clk);
    d_access(we, addr, be, wdata, 1'b0, n, b1);
    chk(n == LAT, {name, "_lat"}, 32'(n), 32'(LAT));
    chk(b1 == 1'b1, {name, "_busy"}, 32'(b1), 32'd1);
  endtask

  task automatic i_chk(input string name, input logic [31:0] addr);
    int n; logic b1;
    @(negedge clk);
    i_fetch(addr, 1'b0, n, b1);
    chk(n == LAT, {name, "_lat"}, 32'(n), 32'(LAT));
  endtask

  // Monitor: pops expectations whenever a ready strobe is seen.
  initial begin
    exp_t e;
    logic [31:0] ie;
    bit p;
    forever begin
      @(negedge clk);
      if (rst_n && (d_ready || i_ready)) begin
        chk(!(d_ready && i_ready), "one_ready", {30'd0, d_ready, i_ready}, 32'd0);
        if (ord_q.size() > 0) begin
          p = ord_q.pop_front();
          chk(p == i_ready, "grant_order", 32'(i_ready), 32'(p));
        end
        if (d_ready) begin
          if (d_q.size() == 0) chk(1'b0, "d_unexpected_ready", 32'd1, 32'd0);
          else begin
            e = d_q.pop_front();
            if (e.we) chk(d_rdata == last_d, "d_rdata_hold", d_rdata, last_d);
            else begin
              chk(d_rdata == e.data, "d_rdata", d_rdata, e.data);
              last_d = e.data;
            end
          end
        end
        if (i_ready) begin
          if (i_q.size() == 0) chk(1'b0, "i_unexpected_ready", 32'd1, 32'd0);
          else begin
            ie = i_q.pop_front();
            chk(i_rdata == ie, "i_rdata", i_rdata, ie);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk(d_ready == 1'b0, {tag, "_d_ready"}, 32'(d_ready), 32'd0);
    chk(i_ready == 1'b0, {tag, "_i_ready"}, 32'(i_ready), 32'd0);
    chk(busy == 1'b0, {tag, "_busy"}, 32'(busy), 32'd0);
    chk(d_rdata == '0, {tag, "_d_rdata"}, d_rdata, 32'd0);
    chk(i_rdata == '0, {tag, "_i_rdata"}, i_rdata, 32'd0);
  endtask

  initial begin
    int n; logic b1;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Latency and cross-port visibility
    d_chk("wr_dead", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    i_chk("fetch_dead", 32'h10);

    // Byte lanes
    d_chk("wr_base", 1'b1, 32'h20, 4'hF, 32'h11223344);
    d_chk("wr_lanes", 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    d_chk("rd_lanes", 1'b0, 32'h20, 4'h0, 32'h0);
    d_chk("wr_be0", 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF);
    d_chk("rd_be0", 1'b0, 32'h22, 4'hF, 32'h0);

    // Address wrap and ignored byte offset
    d_chk("wr_wrap", 1'b1, 32'h100, 4'hF, 32'h5A5A5A5A);
    d_chk("rd_wrap", 1'b0, 32'h000, 4'hF, 32'h0);
    i_chk("fetch_wrap", 32'h0000_0203);

    // Preload every word
    @(negedge clk);
    for (int w = 0; w < 64; w++)
      d_access(1'b1, {$urandom_range(0, 255), w[5:0], 2'b00}, 4'hF, $urandom, w != 63, n, b1);

    // Throughput: four back-to-back reads
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      d_access(1'b0, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, 4'($urandom), 32'h0, k != 3, n, b1);
      if (k == 0) chk(n == LAT, "tput_first", 32'(n), 32'(LAT));
      else begin
        chk(n == LAT + 1, "tput_gap", 32'(n), 32'(LAT + 1));
        chk(b1 == 1'b0, "tput_idle_busy", 32'(b1), 32'd0);
      end
    end

    // Reset in the middle of a data write
    d_chk("wr_pre", 1'b1, 32'h44, 4'hF, 32'h13572468);
    d_chk("rd_pre", 1'b0, 32'h44, 4'hF, 32'h0);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_be = 4'hF; d_wdata = 32'h0BADF00D;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    d_req = 1'b0;
    last_d = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d_chk("rd_after_rst", 1'b0, 32'h44, 4'hF, 32'h0);

    // Arbitration with both ports continuously requesting
    @(negedge clk);
    predict_order(5, 3);
    fork
      begin
        int dn; logic db;
        for (int k = 0; k < 5; k++)
          d_access(1'b0, {24'd0, 1'b0, 5'($urandom), 2'b00}, 4'hF, 32'h0, k != 4, dn, db);
      end
      begin
        int in_; logic ib;
        for (int k = 0; k < 3; k++)
          i_fetch({24'd0, 1'b0, 5'($urandom), 2'($urandom)}, k != 2, in_, ib);
      end
    join
    repeat (2) @(negedge clk);
    chk(ord_q.size() == 0, "order_drained", 32'(ord_q.size()), 32'd0);

    // Random concurrent traffic: data in upper half, fetches in lower half
    fork
      begin
        int dn, gap; logic db;
        for (int k = 0; k < 40; k++) begin
          gap = (k == 39) ? 1 : $urandom_range(0, 2);
          d_access(1'($urandom), {$urandom_range(0, 255), 1'b1, 5'($urandom), 2'($urandom)},
                   4'($urandom), $urandom, gap == 0, dn, db);
          repeat (gap) @(negedge clk);
        end
      end
      begin
        int in_, gap; logic ib;
        for (int k = 0; k < 25; k++) begin
          gap = (k == 24) ? 1 : $urandom_range(0, 2);
          i_fetch({$urandom_range(0, 255), 1'b0, 5'($urandom), 2'($urandom)}, gap == 0, in_, ib);
          repeat (gap) @(negedge clk);
        end
      end
    join

    repeat (6) @(negedge clk);
    chk(d_q.size() == 0, "d_q_drained", 32'(d_q.size()), 32'd0);
    chk(i_q.size() == 0, "i_q_drained", 32'(i_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
